// File: rtl/accel_pkg.sv
// Shared accelerometer types and constants for the frame sampler and display users.
package accel_pkg;
    localparam int ACCEL_W = 8;
    typedef logic signed [ACCEL_W-1:0] accel_t;
    localparam int V_ACTIVE_DEFAULT = 600;

    // Small tilts read as noise; -128 never falls inside a symmetric zone.
    function automatic accel_t dead_zone(accel_t v, int dz);
        return ((int'(v) >= -dz) && (int'(v) <= dz)) ? '0 : v;
    endfunction
endpackage

// File: rtl/accel_axis_filter.sv
// One accelerometer axis: 2-FF resync, stability qualification, frame accumulator, last sample.
module accel_axis_filter
    import accel_pkg::*;
#(
    parameter int SAMPLE_LOG2   = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                 pixel_clk,
    input  logic                                 rst_n,
    input  logic [ACCEL_W-1:0]                   raw_data,
    input  logic                                 accept,
    input  logic                                 clear,
    output logic                                 stable,
    output logic signed [ACCEL_W+SAMPLE_LOG2-1:0] acc,
    output logic signed [ACCEL_W-1:0]            last
);
    localparam int ACC_W = ACCEL_W + SAMPLE_LOG2;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

    logic [ACCEL_W-1:0]      sync_q1, sync_q2, sync_prev;
    logic [CNT_W-1:0]        stab_cnt;
    logic signed [ACC_W-1:0] sample_ext;

    // The counter vouches for sync_prev, so that is the byte that gets sampled.
    assign sample_ext = {{SAMPLE_LOG2{sync_prev[ACCEL_W-1]}}, sync_prev};
    assign stable     = (stab_cnt == CNT_SAT);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            sync_prev <= '0;
            stab_cnt  <= '0;
            acc       <= '0;
            last      <= '0;
        end else begin
            sync_q1   <= raw_data;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
            if (sync_q2 != sync_prev) begin
                stab_cnt <= '0;
            end else if (!stable) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
            if (clear) begin
                acc <= accept ? sample_ext : '0;
            end else if (accept) begin
                acc <= acc + sample_ext;
            end
            if (accept) begin
                last <= sync_prev;
            end
        end
    end
endmodule

// File: rtl/accel_frame_sampler.sv
// Decimates resynchronised X/Y tilt into one value per video frame, published at vblank start.
// Optional ACCEL_DEADZONE_EN forces small per-axis magnitudes (<= DEAD_ZONE) to zero.
module accel_frame_sampler
    import accel_pkg::*;
#(
    parameter int SAMPLE_LOG2   = 4,
    parameter int SAMPLE_DIV    = 2048,
    parameter int STABLE_CYCLES = 4,
    parameter int V_ACTIVE      = V_ACTIVE_DEFAULT
`ifdef ACCEL_DEADZONE_EN
    ,
    parameter int DEAD_ZONE     = 2
`endif
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [7:0] accel_data_x,
    input  logic [7:0] accel_data_y,
    input  logic [9:0] v_coord,
    output logic [7:0] accel_x_frame,
    output logic [7:0] accel_y_frame,
    output logic       frame_valid,
    output logic       frame_stale
);
    localparam int ACC_W = ACCEL_W + SAMPLE_LOG2;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = SAMPLE_LOG2 + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << SAMPLE_LOG2);
    localparam logic [9:0]       V_END    = 10'(V_ACTIVE);

    logic [DIV_W-1:0]        divider;
    logic [CNT_W-1:0]        sample_cnt;
    logic [9:0]              v_coord_d;
    logic                    strobe, frame_end, stable_x, stable_y, accept;
    logic signed [ACC_W-1:0] acc_x, acc_y, avg_x, avg_y;
    logic signed [7:0]       last_x, last_y;
    accel_t                  next_x, next_y;
    logic                    next_stale;

    assign strobe    = (divider == DIV_LAST);
    assign frame_end = (v_coord == V_END) && (v_coord_d != V_END);
    // A strobe on the closing cycle always seeds the next frame, even if this one is full.
    assign accept    = strobe && stable_x && stable_y && (frame_end || (sample_cnt != CNT_FULL));
    assign avg_x     = acc_x >>> SAMPLE_LOG2;
    assign avg_y     = acc_y >>> SAMPLE_LOG2;

    accel_axis_filter #(.SAMPLE_LOG2(SAMPLE_LOG2), .STABLE_CYCLES(STABLE_CYCLES)) u_axis_x (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .raw_data(accel_data_x), .accept(accept),
        .clear(frame_end), .stable(stable_x), .acc(acc_x), .last(last_x)
    );

    accel_axis_filter #(.SAMPLE_LOG2(SAMPLE_LOG2), .STABLE_CYCLES(STABLE_CYCLES)) u_axis_y (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .raw_data(accel_data_y), .accept(accept),
        .clear(frame_end), .stable(stable_y), .acc(acc_y), .last(last_y)
    );

    always_comb begin
        next_x     = accel_x_frame;
        next_y     = accel_y_frame;
        next_stale = 1'b1;
        if (sample_cnt == CNT_FULL) begin
            next_x     = avg_x[ACCEL_W-1:0];
            next_y     = avg_y[ACCEL_W-1:0];
            next_stale = 1'b0;
        end else if (sample_cnt != '0) begin
            next_x = last_x;
            next_y = last_y;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            divider       <= '0;
            sample_cnt    <= '0;
            v_coord_d     <= '0;
            accel_x_frame <= '0;
            accel_y_frame <= '0;
            frame_valid   <= 1'b0;
            frame_stale   <= 1'b0;
        end else begin
            v_coord_d   <= v_coord;
            divider     <= strobe ? '0 : divider + DIV_W'(1);
            frame_valid <= frame_end;
            if (frame_end) begin
                sample_cnt <= accept ? CNT_W'(1) : '0;
`ifdef ACCEL_DEADZONE_EN
                accel_x_frame <= dead_zone(next_x, DEAD_ZONE);
                accel_y_frame <= dead_zone(next_y, DEAD_ZONE);
`else
                accel_x_frame <= next_x;
                accel_y_frame <= next_y;
`endif
                frame_stale <= next_stale;
            end else if (accept) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_accel_frame_sampler.sv
// Scoreboard bench for accel_frame_sampler: frame-level reference model plus a frame_valid monitor.
module tb_accel_frame_sampler;
    localparam int DIV = 64;
    localparam int N   = 16;
    localparam int VA  = 600;
    localparam int DZ  = 2;

    logic       pixel_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] accel_data_x = '0;
    logic [7:0] accel_data_y = '0;
    logic [9:0] v_coord = '0;
    logic [7:0] accel_x_frame, accel_y_frame;
    logic       frame_valid, frame_stale;

    accel_frame_sampler #(.SAMPLE_DIV(DIV)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .accel_data_x(accel_data_x),
        .accel_data_y(accel_data_y), .v_coord(v_coord), .accel_x_frame(accel_x_frame),
        .accel_y_frame(accel_y_frame), .frame_valid(frame_valid), .frame_stale(frame_stale)
    );

    always #14 pixel_clk = ~pixel_clk;

    typedef struct { int x; int y; bit stale; } exp_t;
    exp_t exp_q[$];
    int vectors = 0;
    int errors  = 0;

    // Reference model state: cycle index since reset release and the samples of the open frame.
    int cyc, chg_x, chg_y, prev_v, last_x, last_y, out_x, out_y, sidx;
    int sx[$], sy[$];

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int floor_div(int s);
        return (s >= 0) ? s / N : -((-s + N - 1) / N);
    endfunction

    function automatic int apply_dz(int v);
`ifdef ACCEL_DEADZONE_EN
        return (v >= -DZ && v <= DZ) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int sb(logic [7:0] b);
        return int'($signed(b));
    endfunction

    task automatic model_reset();
        cyc = 0; chg_x = 0; chg_y = 0; prev_v = 0;
        last_x = 0; last_y = 0; out_x = 0; out_y = 0;
        sx.delete(); sy.delete();
    endtask

    task automatic model_eval();
        bit strobe, fe, ok;
        int sum_x, sum_y;
        exp_t e;
        strobe = (cyc % DIV) == DIV - 1;
        fe     = (int'(v_coord) == VA) && (prev_v != VA);
        ok     = strobe && (cyc - chg_x >= 7) && (cyc - chg_y >= 7);
        if (fe) begin
            e.stale = 1'b1;
            if (sx.size() == N) begin
                sum_x = 0; sum_y = 0;
                foreach (sx[i]) begin sum_x += sx[i]; sum_y += sy[i]; end
                out_x = floor_div(sum_x); out_y = floor_div(sum_y);
                e.stale = 1'b0;
            end else if (sx.size() > 0) begin
                out_x = last_x; out_y = last_y;
            end
            out_x = apply_dz(out_x); out_y = apply_dz(out_y);
            e.x = out_x; e.y = out_y;
            exp_q.push_back(e);
            sx.delete(); sy.delete();
        end
        if (ok && (fe || sx.size() < N)) begin
            sx.push_back(sb(accel_data_x)); sy.push_back(sb(accel_data_y));
            last_x = sb(accel_data_x); last_y = sb(accel_data_y);
        end
        prev_v = int'(v_coord);
        cyc++;
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        if (rst_n) model_eval();
        #1;
    endtask

    task automatic set_xy(input int x, input int y);
        logic [7:0] bx, by;
        bx = 8'(x); by = 8'(y);
        if (bx != accel_data_x) chg_x = cyc;
        if (by != accel_data_y) chg_y = cyc;
        accel_data_x = bx; accel_data_y = by;
    endtask

    // mode 0 hold, 1 X alternates 7F/81, 2 X alternates -1/-2 with random Y, 3 fully random
    task automatic run_strobes(input int n, input int mode);
        int got = 0;
        while (got < n) begin
            v_coord = 10'($urandom_range(0, VA - 1));
            if (cyc % DIV == 32) begin
                case (mode)
                    1: set_xy((sidx % 2) ? 'h81 : 'h7F, int'(accel_data_y));
                    2: set_xy((sidx % 2) ? -2 : -1, int'($urandom_range(0, 255)));
                    3: set_xy(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                    default: ;
                endcase
                sidx++;
            end
            if (cyc % DIV == DIV - 1) got++;
            tick();
        end
    endtask

    task automatic end_frame(input bit coincide, input bit toggle, input int min_cycles);
        int target = coincide ? DIV - 1 : 10;
        int n = 0;
        while (n < min_cycles || (cyc % DIV) != target) begin
            v_coord = 10'($urandom_range(0, VA - 1));
            if (toggle && (cyc % 2 == 0)) set_xy(int'(accel_data_x ^ 8'h55), int'(accel_data_y));
            tick();
            n++;
        end
        v_coord = 10'(VA);
        repeat (3) tick();
        v_coord = 10'($urandom_range(0, VA - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, int'(accel_x_frame), 0);
        check({tag, "_y"}, int'(accel_y_frame), 0);
        check({tag, "_valid"}, int'(frame_valid), 0);
        check({tag, "_stale"}, int'(frame_stale), 0);
    endtask

    logic [7:0] hold_x = '0, hold_y = '0;
    always @(negedge pixel_clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_x = '0; hold_y = '0;
        end else if (frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_x", sb(accel_x_frame), e.x);
                check("frame_y", sb(accel_y_frame), e.y);
                check("frame_stale", int'(frame_stale), int'(e.stale));
            end
            hold_x = accel_x_frame; hold_y = accel_y_frame;
        end else begin
            check("hold_between_pulses", int'({accel_x_frame, accel_y_frame}), int'({hold_x, hold_y}));
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        sidx = 0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        set_xy('h10, 'hF0);
        run_strobes(16, 0); end_frame(0, 0, 0);   // 16 / -16, full
        run_strobes(16, 1); end_frame(0, 0, 0);   // 7F/81 cancel to 0
        run_strobes(16, 2); end_frame(0, 0, 0);   // -24/16 floors to -2
        end_frame(0, 1, 4 * DIV);                 // never stable: hold, stale

        run_strobes(5, 3);  end_frame(1, 0, 0);   // coincident strobe seeds next frame
        run_strobes(15, 3); end_frame(0, 0, 0);

        run_strobes(10, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (3) tick();
        model_reset();
        rst_n = 1'b1;
        run_strobes(16, 3); end_frame(0, 0, 0);

        set_xy(2, -3);
        run_strobes(16, 0); end_frame(0, 0, 0);   // dead zone case

        for (int i = 0; i < 6; i++) begin
            run_strobes(int'($urandom_range(0, 18)), 3);
            end_frame(0, 0, 0);
        end

        repeat (20) tick();
        check("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
